int_issue_queue: RTL



---
 rtl/int_issue_queue.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/int_issue_queue.sv
// Integer issue queue: compacting age-ordered buffer, oldest-ready-first select, CDB operand wakeup.
// Optional macro INT_IQ_CDB_BYPASS_EN lets a same-cycle CDB broadcast make an entry issuable.
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_int_dispatch,
    input  logic [6:0]                 d_opcode,
    input  logic [2:0]                 d_func3,
    input  logic [6:0]                 d_func7,
    input  logic [31:0]                d_imm,
    input  logic [31:0]                d_br_addr,
    input  logic [TAG_W-1:0]           d_rd_tag,
    input  logic [31:0]                d_rs1_data,
    input  logic [TAG_W-1:0]           d_rs1_tag,
    input  logic                       d_rs1_pend,
    input  logic [31:0]                d_rs2_data,
    input  logic [TAG_W-1:0]           d_rs2_tag,
    input  logic                       d_rs2_pend,
    input  logic                       cdb_valid,
    input  logic [6:0]                 cdb_tag,
    input  logic [31:0]                cdb_data,
    input  logic                       issue_ready,
    output logic                       issue_valid,
    output logic [6:0]                 issue_opcode,
    output logic [2:0]                 issue_func3,
    output logic [6:0]                 issue_func7,
    output logic [31:0]                issue_imm,
    output logic [31:0]                issue_br_addr,
    output logic [TAG_W-1:0]           issue_rd_tag,
    output logic [31:0]                issue_rs1_data,
    output logic [31:0]                issue_rs2_data,
    output logic                       issueque_int_full,
    output logic [$clog2(DEPTH+1)-1:0] iq_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [31:0]      imm;
        logic [31:0]      br_addr;
        logic [TAG_W-1:0] rd_tag;
        logic [31:0]      rs1_data;
        logic [TAG_W-1:0] rs1_tag;
        logic             rs1_pend;
        logic [31:0]      rs2_data;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs2_pend;
    } entry_t;

    entry_t           entry_r [DEPTH];
    logic [CW-1:0]    count_r;

    entry_t           woken_s [DEPTH+1];
    entry_t           entry_nxt_s [DEPTH];
    entry_t           new_s;
    logic [DEPTH-1:0] wake1_s;
    logic [DEPTH-1:0] wake2_s;
    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] grant_s;
    logic [DEPTH-1:0] prefix_s;
    logic [31:0]      op1_s [DEPTH];
    logic [31:0]      op2_s [DEPTH];
    logic [TAG_W-1:0] cdb_tag_s;
    logic             d_wake1_s;
    logic             d_wake2_s;
    logic             full_s;
    logic             fire_s;
    logic             disp_s;
    logic [CW-1:0]    wr_idx_s;
    logic [CW-1:0]    count_nxt_s;
    logic             cdb_tag_unused_s;

    // Only the low TAG_W bits of the broadcast tag identify a producer.
    assign cdb_tag_s        = cdb_tag[TAG_W-1:0];
    assign cdb_tag_unused_s = ^cdb_tag;

    assign full_s = (count_r == CNT_FULL);
    assign fire_s = issue_valid & issue_ready;
    assign disp_s = en_int_dispatch & ~full_s;

    assign issueque_int_full = full_s;
    assign iq_count          = count_r;

    // Per-entry CDB tag match, readiness and operand values presented at issue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1_s[i] = cdb_valid & entry_r[i].valid & entry_r[i].rs1_pend &
                         (entry_r[i].rs1_tag == cdb_tag_s);
            wake2_s[i] = cdb_valid & entry_r[i].valid & entry_r[i].rs2_pend &
                         (entry_r[i].rs2_tag == cdb_tag_s);
`ifdef INT_IQ_CDB_BYPASS_EN
            ready_s[i] = entry_r[i].valid & (~entry_r[i].rs1_pend | wake1_s[i]) &
                         (~entry_r[i].rs2_pend | wake2_s[i]);
            op1_s[i]   = wake1_s[i] ? cdb_data : entry_r[i].rs1_data;
            op2_s[i]   = wake2_s[i] ? cdb_data : entry_r[i].rs2_data;
`else
            ready_s[i] = entry_r[i].valid & ~entry_r[i].rs1_pend & ~entry_r[i].rs2_pend;
            op1_s[i]   = entry_r[i].rs1_data;
            op2_s[i]   = entry_r[i].rs2_data;
`endif
        end
    end

    // Oldest-ready grant and one-hot AND-OR output mux; all zero when nothing is ready.
    always_comb begin
        logic seen;
        seen           = 1'b0;
        issue_opcode   = '0;
        issue_func3    = '0;
        issue_func7    = '0;
        issue_imm      = '0;
        issue_br_addr  = '0;
        issue_rd_tag   = '0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_s[i]     = ready_s[i] & ~seen;
            seen           = seen | ready_s[i];
            prefix_s[i]    = seen;
            issue_opcode   = issue_opcode   | ({7{grant_s[i]}}     & entry_r[i].opcode);
            issue_func3    = issue_func3    | ({3{grant_s[i]}}     & entry_r[i].func3);
            issue_func7    = issue_func7    | ({7{grant_s[i]}}     & entry_r[i].func7);
            issue_imm      = issue_imm      | ({32{grant_s[i]}}    & entry_r[i].imm);
            issue_br_addr  = issue_br_addr  | ({32{grant_s[i]}}    & entry_r[i].br_addr);
            issue_rd_tag   = issue_rd_tag   | ({TAG_W{grant_s[i]}} & entry_r[i].rd_tag);
            issue_rs1_data = issue_rs1_data | ({32{grant_s[i]}}    & op1_s[i]);
            issue_rs2_data = issue_rs2_data | ({32{grant_s[i]}}    & op2_s[i]);
        end
        issue_valid = seen;
    end

    // Incoming instruction, capturing a matching CDB broadcast in the same cycle.
    always_comb begin
        d_wake1_s      = d_rs1_pend & cdb_valid & (d_rs1_tag == cdb_tag_s);
        d_wake2_s      = d_rs2_pend & cdb_valid & (d_rs2_tag == cdb_tag_s);
        new_s.valid    = 1'b1;
        new_s.opcode   = d_opcode;
        new_s.func3    = d_func3;
        new_s.func7    = d_func7;
        new_s.imm      = d_imm;
        new_s.br_addr  = d_br_addr;
        new_s.rd_tag   = d_rd_tag;
        new_s.rs1_tag  = d_rs1_tag;
        new_s.rs1_data = d_wake1_s ? cdb_data : d_rs1_data;
        new_s.rs1_pend = d_rs1_pend & ~d_wake1_s;
        new_s.rs2_tag  = d_rs2_tag;
        new_s.rs2_data = d_wake2_s ? cdb_data : d_rs2_data;
        new_s.rs2_pend = d_rs2_pend & ~d_wake2_s;
    end

    // Write slot and occupancy update; an issuing cycle frees the top slot before the write.
    always_comb begin
        wr_idx_s = fire_s ? (count_r - CNT_ONE) : count_r;
        case ({disp_s, fire_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Wakeup is applied before compaction so an entry moving down still captures.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken_s[i]          = entry_r[i];
            woken_s[i].rs1_data = wake1_s[i] ? cdb_data : entry_r[i].rs1_data;
            woken_s[i].rs1_pend = entry_r[i].rs1_pend & ~wake1_s[i];
            woken_s[i].rs2_data = wake2_s[i] ? cdb_data : entry_r[i].rs2_data;
            woken_s[i].rs2_pend = entry_r[i].rs2_pend & ~wake2_s[i];
        end
        woken_s[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_s && (CW'(i) == wr_idx_s)) begin
                entry_nxt_s[i] = new_s;
            end else if (fire_s && prefix_s[i]) begin
                entry_nxt_s[i] = woken_s[i+1];
            end else begin
                entry_nxt_s[i] = woken_s[i];
            end
        end
    end

    // State register; reset overrides dispatch, issue and wakeup.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            count_r <= count_nxt_s;
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= entry_nxt_s[i];
            end
        end
    end

endmodule
